// File: rtl/packed_dual_mac_if.sv
// Beat/result bundle for packed_dual_mac.
// Purpose: carries one accumulation beat (two activations plus a shared
// weight, framed by first/last flags) towards the MAC and one windowed
// result pair back out.
// Signals:
//   in_valid, in_first, in_last, act_signed : beat qualifiers
//   in_a, in_b, in_w                        : lane A/B activations, weight
//   out_valid                               : one-cycle result pulse
//   out_ac, out_bc                          : lane A/B window sums (signed)
//   out_sat                                 : {lane A, lane B} clamp seen
// Modports: master drives beats (fetch side), slave is the MAC itself.
interface packed_dual_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic                     in_valid;
  logic                     in_first;
  logic                     in_last;
  logic                     act_signed;
  logic [DATA_W-1:0]        in_a;
  logic [DATA_W-1:0]        in_b;
  logic [DATA_W-1:0]        in_w;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_ac;
  logic signed [ACC_W-1:0]  out_bc;
  logic [1:0]               out_sat;

  modport master (
    output in_valid, in_first, in_last, act_signed, in_a, in_b, in_w,
    input  out_valid, out_ac, out_bc, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, act_signed, in_a, in_b, in_w,
    output out_valid, out_ac, out_bc, out_sat
  );
endinterface

// File: rtl/packed_dual_mac.sv
// packed_dual_mac: two activations times one shared weight per beat using a
// single packed multiplier, with per-lane saturating window accumulation.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every stage
//   bus  : packed_dual_mac_if.slave (beat inputs, result outputs)
// Pipeline: S1 operand/flag capture, S2 packed product + sign-borrow
// correction, S3 accumulate/saturate, then the result register.
module packed_dual_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  packed_dual_mac_if.slave bus
);
  localparam int X_W  = DATA_W + 1;
  localparam int P_W  = 2 * DATA_W + 1;
  localparam int S    = P_W;
  localparam int OP_W = X_W + S;
  localparam int M_W  = 2 * S;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic              s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic              s1_last_q, s1_last_d, s1_signed_q, s1_signed_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_w_q, s1_w_d;

  logic              s2_valid_q, s2_valid_d, s2_first_q, s2_first_d;
  logic              s2_last_q, s2_last_d;
  logic [P_W-1:0]    s2_prod_a_q, s2_prod_a_d, s2_prod_b_q, s2_prod_b_d;

  logic [ACC_W-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic              sat_a_q, sat_a_d, sat_b_q, sat_b_d;
  logic              open_q, open_d, res_q, res_d;

  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_ac_q, out_ac_d, out_bc_q, out_bc_d;
  logic [1:0]        out_sat_q, out_sat_d;

  logic [X_W-1:0]    a_ext, b_ext, w_ext;
  logic [OP_W-1:0]   op_packed;
  logic [M_W-1:0]    op_m, w_m, prod_packed;
  logic [ACC_W-1:0]  ext_a, ext_b, base_a, base_b;
  logic [ACC_W:0]    sum_a, sum_b;
  logic              beat_first, ovf_a, ovf_b;

  // S1 simply captures the beat; data is captured even in bubbles because
  // only the valid bit matters downstream.
  always_comb begin
    s1_valid_d  = bus.in_valid;
    s1_first_d  = bus.in_first;
    s1_last_d   = bus.in_last;
    s1_signed_d = bus.act_signed;
    s1_a_d      = bus.in_a;
    s1_b_d      = bus.in_b;
    s1_w_d      = bus.in_w;
  end

  // S2: one multiply of (a << S) + b by w. The low S bits are exactly b*w;
  // the high half is a*w minus one whenever b*w went negative, so adding
  // back the lane B sign bit restores lane A.
  always_comb begin
    a_ext       = {s1_signed_q & s1_a_q[DATA_W-1], s1_a_q};
    b_ext       = {s1_signed_q & s1_b_q[DATA_W-1], s1_b_q};
    w_ext       = {s1_w_q[DATA_W-1], s1_w_q};
    op_packed   = {a_ext, {S{1'b0}}} + {{S{b_ext[X_W-1]}}, b_ext};
    op_m        = {{(M_W-OP_W){op_packed[OP_W-1]}}, op_packed};
    w_m         = {{(M_W-X_W){w_ext[X_W-1]}}, w_ext};
    prod_packed = op_m * w_m;
    s2_valid_d  = s1_valid_q;
    s2_first_d  = s1_first_q;
    s2_last_d   = s1_last_q;
    s2_prod_b_d = prod_packed[S-1:0];
    s2_prod_a_d = prod_packed[M_W-1:S] + {{(S-1){1'b0}}, prod_packed[S-1]};
  end

  // S3: a beat opens a fresh window when flagged first or when no window is
  // open. The sum is formed one bit wider so overflow shows as a mismatch
  // between the top two bits, and the result clamps towards that sign.
  always_comb begin
    beat_first = s2_first_q | ~open_q;
    ext_a      = {{(ACC_W-P_W){s2_prod_a_q[P_W-1]}}, s2_prod_a_q};
    ext_b      = {{(ACC_W-P_W){s2_prod_b_q[P_W-1]}}, s2_prod_b_q};
    base_a     = beat_first ? '0 : acc_a_q;
    base_b     = beat_first ? '0 : acc_b_q;
    sum_a      = {base_a[ACC_W-1], base_a} + {ext_a[ACC_W-1], ext_a};
    sum_b      = {base_b[ACC_W-1], base_b} + {ext_b[ACC_W-1], ext_b};
    ovf_a      = sum_a[ACC_W] ^ sum_a[ACC_W-1];
    ovf_b      = sum_b[ACC_W] ^ sum_b[ACC_W-1];
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    sat_a_d    = sat_a_q;
    sat_b_d    = sat_b_q;
    open_d     = open_q;
    res_d      = s2_valid_q & s2_last_q;
    if (s2_valid_q) begin
      acc_a_d = ovf_a ? (sum_a[ACC_W] ? ACC_MIN : ACC_MAX) : sum_a[ACC_W-1:0];
      acc_b_d = ovf_b ? (sum_b[ACC_W] ? ACC_MIN : ACC_MAX) : sum_b[ACC_W-1:0];
      sat_a_d = (sat_a_q & ~beat_first) | ovf_a;
      sat_b_d = (sat_b_q & ~beat_first) | ovf_b;
      open_d  = ~s2_last_q;
    end
  end

  // Result register samples the accumulators the cycle after a closing
  // beat, so the next window's first beat can overwrite them in parallel.
  always_comb begin
    out_valid_d = res_q;
    out_ac_d    = res_q ? acc_a_q : out_ac_q;
    out_bc_d    = res_q ? acc_b_q : out_bc_q;
    out_sat_d   = res_q ? {sat_a_q, sat_b_q} : out_sat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_w_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_a_q <= '0;
      s2_prod_b_q <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      sat_a_q     <= 1'b0;
      sat_b_q     <= 1'b0;
      open_q      <= 1'b0;
      res_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ac_q    <= '0;
      out_bc_q    <= '0;
      out_sat_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_signed_q <= s1_signed_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_w_q      <= s1_w_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_prod_a_q <= s2_prod_a_d;
      s2_prod_b_q <= s2_prod_b_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      sat_a_q     <= sat_a_d;
      sat_b_q     <= sat_b_d;
      open_q      <= open_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      out_ac_q    <= out_ac_d;
      out_bc_q    <= out_bc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ac    = out_ac_q;
  assign bus.out_bc    = out_bc_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: doc/packed_dual_mac.md
# packed_dual_mac

Parametrised successor to the packed dual-multiply stage of the conv datapath. Two activations (a, b) are multiplied by one shared weight w per beat using a single packed multiplier, and the two products are accumulated over a window of beats framed by first/last flags. The block adds three things to the packed multiply:
- exact sign-borrow correction,
- per-beat signed/unsigned activation mode,
- saturating accumulation with a sticky overflow flag.

It sits between the activation/weight fetch and the requantiser; one instance serves two adjacent output pixels.

## Interface
Parameters:
- DATA_W, 8, activation and weight width (≥2)
- ACC_W, 24, accumulator and result width, signed; must be ≥ 2*DATA_W+2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid; no backpressure, a beat is accepted every cycle in_valid=1
- in_first  in  1  beat opens a new accumulation window
- in_last  in  1  beat closes the window and produces a result
- act_signed  in  1  1: a,b two's complement; 0: a,b unsigned; sampled per beat
- in_a  in  DATA_W  activation for lane A
- in_b  in  DATA_W  activation for lane B
- in_w  in  DATA_W  shared weight, always signed
- out_valid  out  1  one-cycle pulse, result valid
- out_ac  out  ACC_W  lane A window sum, signed
- out_bc  out  ACC_W  lane B window sum, signed
- out_sat  out  2  {lane A, lane B} saturation occurred in this window

## Operation
- Operand extension: a and b are sign-extended or zero-extended to DATA_W+1 bits, selected by act_signed. w is sign-extended.
- Product width: P_W = 2*DATA_W+1 signed. Each product is bit-exact equal to the separate products a*w and b*w.
- Packing: one multiplier computes ({a_ext, S zeros} + sext(b_ext)) * w_ext with S = P_W.
  - Lane B product = packed[S-1:0].
  - Lane A product = packed[2S-1:S] + packed[S-1]. This is a borrow from the lane B sign, not from the weight sign.
- Accumulators: one per lane, ACC_W bits, signed.
- A beat with in_first=1 loads acc <= sext(prod).
- Any other beat computes acc <= sat(acc + sext(prod)).
  - Result clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The lane's sticky sat bit is set whenever a clamp occurs.
  - in_first clears both sticky bits before the beat's own add.
- Window state: a one-bit open flag is set by any beat and cleared by in_last.
  - A beat arriving while the window is closed is treated as in_first, even if in_first=0.
  - in_first while the window is open discards the partial sums. No error is flagged.
- Result: a beat with in_last=1 registers the post-add acc values into out_ac/out_bc and the sticky bits into out_sat, and asserts out_valid for exactly one cycle.
  - in_first=in_last=1 gives a single-term result.
- Bubbles: in_valid=0 cycles change no accumulator or flag state. They travel down the pipeline as invalid slots.
- Holding outputs: out_ac, out_bc and out_sat hold their value until the next result. out_valid=0 between results.

## Timing
- Pipeline of 3 registered stages: S1 operand/flag capture, S2 packed product and correction, S3 accumulate/saturate.
- Result latency: the beat accepted at edge N with in_last=1 gives out_valid=1 and its data on the cycle after edge N+3, i.e. 3 cycles.
- Throughput: one beat per cycle. Windows may be back-to-back: in_last at edge N and in_first at edge N+1 produce results at N+3 and N+4.
- act_signed and the flags travel with their beat through every stage. A mode change between consecutive beats takes effect exactly at that beat.
- Reset: asynchronous assert clears all stages.
  - All valid bits = 0, accumulators = 0, sticky = 0, window closed.
  - Outputs: out_valid=0, out_ac=0, out_bc=0, out_sat=0.
  - A window in progress is discarded and produces no result.
  - The first beat after deassert is treated as first.

## Test plan
- Signed single-term: DATA_W=8, act_signed=1, a=3, b=-5, w=-7, first=last=1 -> 3 cycles later out_valid pulse, out_ac=-21, out_bc=35, out_sat=0.
- Sign-borrow correction:
  - a=1, b=-1, w=1 (signed) -> out_ac=1, out_bc=-1.
  - a=-128, b=-128, w=-128 -> out_ac=16384, out_bc=16384.
- Unsigned mode: act_signed=0, a=200, b=255, w=-128 -> out_ac=-25600, out_bc=-32640. Then the same codes with act_signed=1 on the next window -> out_ac=7168, out_bc=128.
- Back-to-back windows with bubbles:
  - Window 1: 4 beats of a=2, b=3, w=5, with one in_valid=0 gap.
  - Window 2: single beat a=1, b=1, w=1 starting the cycle after the last beat of window 1.
  - Required: two out_valid pulses exactly 1 cycle apart, window 1 (40, 60), window 2 (1, 1).
- Saturation: act_signed=0, a=255, b=1, w=-128, 260 beats -> out_ac=-8388608, out_sat=2'b10, out_bc=-33280. The next window of one beat, a=1, b=1, w=1, gives out_sat=2'b00.
- Reset mid-window: 3 beats accumulated, rst pulsed before in_last -> all outputs 0 immediately. No out_valid for the broken window. The next beat with in_first=0 and in_last=1, a=4, b=4, w=4, gives out_ac=16, out_bc=16.
